// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-side controller for the 32x32 register file.
// Accepts MEM/WB results, waits on dhit for loads, and drives a registered
// write port (WEN/wsel/wdat). A busy scoreboard stalls decode on RAW/WAW.
//
// Ports:
//   CLK, nRST              clock, async active-low reset
//   issue_valid/issue_wsel decode issuing a write to issue_wsel
//   rs_sel/rt_sel          decode source registers
//   stall                  decode must hold (combinational)
//   wb_valid/wb_wsel/...   MEM/WB result; wb_ready = accepted this cycle
//   dhit/dmemload          load data return
//   WEN/wsel/wdat          registered register-file write port
//   busy_vec               per-register outstanding-write scoreboard

module regfile_wb_ctrl #(
  parameter int NREG = 32
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            issue_valid,
  input  logic [4:0]      issue_wsel,
  input  logic [4:0]      rs_sel,
  input  logic [4:0]      rt_sel,
  output logic            stall,
  input  logic            wb_valid,
  input  logic [4:0]      wb_wsel,
  input  logic [31:0]     wb_wdat,
  input  logic            wb_is_load,
  input  logic            wb_is_jal,
  input  logic [31:0]     wb_npc,
  output logic            wb_ready,
  input  logic            dhit,
  input  logic [31:0]     dmemload,
  output logic            WEN,
  output logic [4:0]      wsel,
  output logic [31:0]     wdat,
  output logic [NREG-1:0] busy_vec
);

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [4:0]       ldsel_q;
  logic [4:0]       ldsel_d;
  logic             wen_q;
  logic             wen_d;
  logic [4:0]       wsel_q;
  logic [4:0]       wsel_d;
  logic [31:0]      wdat_q;
  logic [31:0]      wdat_d;
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;

  logic [4:0]       res_sel;
  logic [31:0]      res_dat;
  logic             issue_go;

  // Link writes always target r31 with the next-PC as data.
  always_comb begin
    res_sel = wb_is_jal ? 5'd31 : wb_wsel;
    res_dat = wb_is_jal ? wb_npc : wb_wdat;
  end

  // busy_q[0] is held at zero, so r0 can never raise stall.
  // The issue_wsel term blocks WAW: one outstanding write per register.
  always_comb begin
    stall = busy_q[rs_sel]
          | busy_q[rt_sel]
          | busy_q[issue_wsel];
  end

  always_comb begin
    issue_go = issue_valid
             & ~stall
             & (issue_wsel != 5'd0);
  end

  // Writeback path. wsel/wdat hold their value when no write is issued;
  // writes resolving to r0 are dropped without a WEN pulse.
  always_comb begin
    state_d = state_q;
    ldsel_d = ldsel_q;
    wen_d   = 1'b0;
    wsel_d  = wsel_q;
    wdat_d  = wdat_q;
    unique case (state_q)
      IDLE: begin
        if (wb_valid) begin
          if (wb_is_load) begin
            ldsel_d = wb_wsel;
            state_d = LOAD_WAIT;
          end else if (res_sel != 5'd0) begin
            wen_d  = 1'b1;
            wsel_d = res_sel;
            wdat_d = res_dat;
          end
        end
      end
      LOAD_WAIT: begin
        if (dhit) begin
          state_d = IDLE;
          if (ldsel_q != 5'd0) begin
            wen_d  = 1'b1;
            wsel_d = ldsel_q;
            wdat_d = dmemload;
          end
        end
      end
    endcase
  end

  // Clear on the edge the register file stores the data; a set on the
  // same edge takes priority.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[wsel_q] = 1'b0;
    end
    if (issue_go) begin
      busy_d[issue_wsel] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ldsel_q <= 5'd0;
      wen_q   <= 1'b0;
      wsel_q  <= 5'd0;
      wdat_q  <= 32'd0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      ldsel_q <= ldsel_d;
      wen_q   <= wen_d;
      wsel_q  <= wsel_d;
      wdat_q  <= wdat_d;
      busy_q  <= busy_d;
    end
  end

  assign wb_ready = (state_q == IDLE);
  assign WEN      = wen_q;
  assign wsel     = wsel_q;
  assign wdat     = wdat_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of the writeback controller.

module tb_regfile_wb_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_wsel = 5'd0;
  logic [4:0]  rs_sel = 5'd0;
  logic [4:0]  rt_sel = 5'd0;
  logic        stall;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_wsel = 5'd0;
  logic [31:0] wb_wdat = 32'd0;
  logic        wb_is_load = 1'b0;
  logic        wb_is_jal = 1'b0;
  logic [31:0] wb_npc = 32'd0;
  logic        wb_ready;
  logic        dhit = 1'b0;
  logic [31:0] dmemload = 32'd0;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [31:0] busy_vec;

  int errors = 0;
  int checks = 0;

  regfile_wb_ctrl #(.NREG(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .issue_valid(issue_valid), .issue_wsel(issue_wsel),
    .rs_sel(rs_sel), .rt_sel(rt_sel), .stall(stall),
    .wb_valid(wb_valid), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .wb_is_load(wb_is_load), .wb_is_jal(wb_is_jal), .wb_npc(wb_npc),
    .wb_ready(wb_ready), .dhit(dhit), .dmemload(dmemload),
    .WEN(WEN), .wsel(wsel), .wdat(wdat), .busy_vec(busy_vec)
  );

  always #5 CLK = ~CLK;

  // Reference model: outstanding-write set, pending load, last write.
  bit          m_busy [32];
  bit          m_lw;
  bit [4:0]    m_ldsel;
  bit          m_wen;
  bit [4:0]    m_wsel;
  bit [31:0]   m_wdat;

  function automatic void m_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_lw = 0; m_ldsel = 0;
    m_wen = 0; m_wsel = 0; m_wdat = 0;
  endfunction

  function automatic bit m_stall();
    return m_busy[rs_sel] || m_busy[rt_sel] || m_busy[issue_wsel];
  endfunction

  function automatic bit [31:0] m_vec();
    bit [31:0] v = 0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic void model_edge();
    bit       st;
    bit [4:0] dest;
    st = m_stall();
    if (m_wen) m_busy[m_wsel] = 1'b0;
    if (issue_valid && !st && issue_wsel != 0) m_busy[issue_wsel] = 1'b1;
    m_wen = 0;
    if (m_lw) begin
      if (dhit) begin
        m_lw = 0;
        if (m_ldsel != 0) begin
          m_wen = 1; m_wsel = m_ldsel; m_wdat = dmemload;
        end
      end
    end else if (wb_valid) begin
      if (wb_is_load) begin
        m_lw = 1; m_ldsel = wb_wsel;
      end else begin
        dest = wb_is_jal ? 5'd31 : wb_wsel;
        if (dest != 0) begin
          m_wen = 1; m_wsel = dest;
          m_wdat = wb_is_jal ? wb_npc : wb_wdat;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 0;
    m_reset();
    @(negedge CLK); @(negedge CLK);
    checks++;
    if (WEN !== 1'b0) begin
      errors++; $display("FAIL reset_wen: got %b want 0", WEN);
    end
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++; $display("FAIL reset_busy: got %h want 0", busy_vec);
    end
    checks++;
    if (wb_ready !== 1'b1 || wsel !== 5'd0 || wdat !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: ready=%b wsel=%0d wdat=%h want 1/0/0",
               wb_ready, wsel, wdat);
    end
    nRST = 1;
    @(negedge CLK);
  endtask

  task automatic test_alu_write();
    issue_valid = 1; issue_wsel = 8;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL alu_issue_stall: got %b want 0", stall);
    end
    tick();
    checks++;
    if (busy_vec !== 32'h100) begin
      errors++; $display("FAIL alu_busy_set: got %h want 100", busy_vec);
    end
    issue_valid = 0; issue_wsel = 0; rs_sel = 8;
    wb_valid = 1; wb_wsel = 8; wb_wdat = 32'hDEADBEEF;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL alu_raw_stall: got %b want 1", stall);
    end
    tick();
    wb_valid = 0;
    checks++;
    if (WEN !== 1'b1 || wsel !== 5'd8 || wdat !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL alu_write: WEN=%b wsel=%0d wdat=%h want 1/8/deadbeef",
               WEN, wsel, wdat);
    end
    checks++;
    if (busy_vec !== 32'h100) begin
      errors++; $display("FAIL alu_busy_hold: got %h want 100", busy_vec);
    end
    tick();
    checks++;
    if (busy_vec !== 32'd0 || WEN !== 1'b0) begin
      errors++;
      $display("FAIL alu_busy_clear: busy=%h WEN=%b want 0/0", busy_vec, WEN);
    end
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL alu_stall_drop: got %b want 0", stall);
    end
    rs_sel = 0;
  endtask

  task automatic test_load();
    int pulses = 0;
    issue_valid = 1; issue_wsel = 5;
    tick();
    issue_valid = 0; issue_wsel = 0;
    wb_valid = 1; wb_wsel = 5; wb_is_load = 1; wb_wdat = 32'h5555;
    tick();
    // Offer a competing result during the wait; it must not be taken.
    wb_is_load = 0; wb_wsel = 9; wb_wdat = 32'h9999;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3); dmemload = 32'h1234;
      #1;
      checks++;
      if (wb_ready !== 1'b0) begin
        errors++; $display("FAIL load_ready_c%0d: got %b want 0", i, wb_ready);
      end
      tick();
      pulses += (WEN === 1'b1) ? 1 : 0;
    end
    wb_valid = 0; dhit = 0;
    checks++;
    if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== 32'h1234) begin
      errors++;
      $display("FAIL load_write: WEN=%b wsel=%0d wdat=%h want 1/5/1234",
               WEN, wsel, wdat);
    end
    tick();
    pulses += (WEN === 1'b1) ? 1 : 0;
    checks++;
    if (pulses != 1 || busy_vec !== 32'd0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_single: pulses=%0d busy=%h ready=%b want 1/0/1",
               pulses, busy_vec, wb_ready);
    end
  endtask

  task automatic test_jal();
    wb_valid = 1; wb_wsel = 0; wb_is_jal = 1;
    wb_npc = 32'h400; wb_wdat = 32'hBAD0BAD0;
    tick();
    wb_valid = 0; wb_is_jal = 0;
    checks++;
    if (WEN !== 1'b1 || wsel !== 5'd31 || wdat !== 32'h400) begin
      errors++;
      $display("FAIL jal_write: WEN=%b wsel=%0d wdat=%h want 1/31/400",
               WEN, wsel, wdat);
    end
    tick();
  endtask

  task automatic test_zero_dest();
    wb_valid = 1; wb_wsel = 0; wb_wdat = 32'hCAFE;
    tick();
    wb_valid = 0;
    checks++;
    if (WEN !== 1'b0) begin
      errors++; $display("FAIL zero_write: WEN=%b want 0", WEN);
    end
    issue_valid = 1; issue_wsel = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL zero_issue_stall: got %b want 0", stall);
    end
    tick();
    issue_valid = 0;
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++; $display("FAIL zero_issue_busy: got %h want 0", busy_vec);
    end
  endtask

  task automatic test_set_wins();
    issue_valid = 1; issue_wsel = 12;
    tick();
    issue_valid = 0; issue_wsel = 0;
    wb_valid = 1; wb_wsel = 12; wb_wdat = 32'h0C0C;
    tick();
    wb_valid = 0;
    issue_valid = 1; issue_wsel = 12;
    #1;
    checks++;
    if (stall !== 1'b1 || WEN !== 1'b1) begin
      errors++;
      $display("FAIL sw_pulse_stall: stall=%b WEN=%b want 1/1", stall, WEN);
    end
    tick();
    checks++;
    if (busy_vec !== 32'd0) begin
      errors++; $display("FAIL sw_cleared: got %h want 0", busy_vec);
    end
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL sw_after_clear: got %b want 0", stall);
    end
    tick();
    checks++;
    if (busy_vec !== 32'h1000) begin
      errors++; $display("FAIL sw_reissue: got %h want 1000", busy_vec);
    end
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL sw_waw_stall: got %b want 1", stall);
    end
    tick();
    issue_valid = 0; issue_wsel = 0;
    checks++;
    if (busy_vec !== 32'h1000) begin
      errors++; $display("FAIL sw_ignored: got %h want 1000", busy_vec);
    end
    wb_valid = 1; wb_wsel = 12;
    tick();
    wb_valid = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1; wb_wsel = 5'(i + 16); wb_wdat = 32'h11111111 * i;
      tick();
      checks++;
      if (WEN !== 1'b1 || wsel !== 5'(i + 16) ||
          wdat !== 32'h11111111 * i) begin
        errors++;
        $display("FAIL b2b_%0d: WEN=%b wsel=%0d wdat=%h want 1/%0d/%h",
                 i, WEN, wsel, wdat, i + 16, 32'h11111111 * i);
      end
    end
    wb_valid = 0;
    tick();
    checks++;
    if (WEN !== 1'b0) begin
      errors++; $display("FAIL b2b_end: WEN=%b want 0", WEN);
    end
  endtask

  task automatic test_reset_in_load();
    issue_valid = 1; issue_wsel = 7;
    tick();
    issue_valid = 0; issue_wsel = 0;
    wb_valid = 1; wb_wsel = 7; wb_is_load = 1;
    tick();
    wb_valid = 0; wb_is_load = 0;
    tick();
    #2 nRST = 0;
    #1;
    checks++;
    if (WEN !== 1'b0 || busy_vec !== 32'd0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_load_async: WEN=%b busy=%h ready=%b want 0/0/1",
               WEN, busy_vec, wb_ready);
    end
    @(negedge CLK);
    nRST = 1;
    m_reset();
    dhit = 1; dmemload = 32'hFEED;
    tick();
    dhit = 0;
    checks++;
    if (WEN !== 1'b0 || busy_vec !== 32'd0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_load_dhit: WEN=%b busy=%h ready=%b want 0/0/1",
               WEN, busy_vec, wb_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_wsel  = 5'($urandom_range(0, 7));
      rs_sel      = 5'($urandom_range(0, 7));
      rt_sel      = 5'($urandom_range(0, 7));
      wb_valid    = ($urandom_range(0, 9) < 6);
      wb_wsel     = 5'($urandom_range(0, 7));
      wb_wdat     = $urandom;
      wb_is_load  = ($urandom_range(0, 3) == 0);
      wb_is_jal   = ($urandom_range(0, 6) == 0);
      wb_npc      = $urandom;
      dhit        = ($urandom_range(0, 9) < 4);
      dmemload    = $urandom;
      #1;
      checks++;
      if (stall !== m_stall() || wb_ready !== !m_lw) begin
        errors++;
        $display("FAIL rnd_comb_%0d: stall=%b ready=%b want %b/%b",
                 n, stall, wb_ready, m_stall(), !m_lw);
      end
      tick();
      checks++;
      if (WEN !== m_wen || busy_vec !== m_vec() ||
          (m_wen && (wsel !== m_wsel || wdat !== m_wdat))) begin
        errors++;
        $display("FAIL rnd_out_%0d: WEN=%b wsel=%0d wdat=%h busy=%h want %b/%0d/%h/%h",
                 n, WEN, wsel, wdat, busy_vec, m_wen, m_wsel, m_wdat, m_vec());
      end
    end
    issue_valid = 0; wb_valid = 0; dhit = 0;
    issue_wsel = 0; rs_sel = 0; rt_sel = 0;
    wb_is_load = 0; wb_is_jal = 0;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load();
    test_jal();
    test_zero_dest();
    test_set_wins();
    test_back_to_back();
    test_reset_in_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
